pooling_array_param: RTL and testbench



---
 rtl/pooling_array_param_if.sv | 26 ++
 rtl/pooling_array_param.sv | 126 ++++++++++++
 tb/tb_pooling_array_param.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pooling_array_param_if.sv
// Stream bundle for the pooling engine: input beats, result handshake and status.
// The master side drives beats and accepts results; the slave side is the engine.
interface pooling_array_param_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 3
);
  logic                           mode;
  logic                           clear;
  logic                           in_valid;
  logic                           in_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] data_in;
  logic                           out_valid;
  logic                           out_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] data_out;
  logic                           busy;

  modport master (
    output mode, clear, in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  mode, clear, in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/pooling_array_param.sv
// Multi-lane pooling engine: reduces every WINDOW accepted beats per lane to a signed
// max or a floor-average, and holds the result on a ready/valid output.
module pooling_array_param #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 3,
  parameter int WINDOW     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pooling_array_param_if.slave bus
);

  localparam int LOG2W = $clog2(WINDOW);
  localparam int ACC_W = DATA_WIDTH + LOG2W;
  localparam int BUS_W = CHANNELS * DATA_WIDTH;

  if (CHANNELS < 1 || WINDOW < 2 || WINDOW > 64 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_param
    $error("pooling_array_param: CHANNELS must be >=1 and WINDOW a power of two in 2..64");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LOG2W-1:0]        r_cnt;
  logic [LOG2W-1:0]        w_cnt_nxt;
  logic                    r_mode_q;
  logic                    r_out_valid;
  logic [BUS_W-1:0]        r_data_out;
  logic [BUS_W-1:0]        w_result;
  logic signed [ACC_W-1:0] r_acc     [CHANNELS];
  logic signed [ACC_W-1:0] w_acc_nxt [CHANNELS];

  logic w_in_ready;
  logic w_accept;
  logic w_first;
  logic w_last;
  logic w_mode_eff;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready && !bus.clear;
  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == LOG2W'(WINDOW - 1));
  // The first beat of a window uses the live mode pin; later beats use the latched copy.
  assign w_mode_eff = w_first ? bus.mode : r_mode_q;

  // Per-lane datapath. Lane 0 sits in the MSBs of the packed bus.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] w_sample;
    logic signed [ACC_W-1:0]      w_sext;
    logic signed [ACC_W-1:0]      w_max;
    logic signed [ACC_W-1:0]      w_sum;
    logic        [DATA_WIDTH-1:0] w_avg;

    assign w_sample = bus.data_in[(CHANNELS-1-g)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sext   = {{LOG2W{w_sample[DATA_WIDTH-1]}}, w_sample};
    assign w_max    = (w_first || (w_sext > r_acc[g])) ? w_sext : r_acc[g];
    assign w_sum    = w_first ? w_sext : (r_acc[g] + w_sext);
    // Arithmetic shift floors toward minus infinity; the quotient always fits DATA_WIDTH.
    assign w_avg    = DATA_WIDTH'(w_sum >>> LOG2W);

    assign w_acc_nxt[g] = w_mode_eff ? w_sum : w_max;
    assign w_result[(CHANNELS-1-g)*DATA_WIDTH +: DATA_WIDTH] =
      w_mode_eff ? w_avg : w_max[DATA_WIDTH-1:0];
  end

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.clear) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      w_cnt_nxt = w_last ? '0 : (r_cnt + LOG2W'(1));
      unique case (r_state)
        S_IDLE:  if (!w_last) w_state_nxt = S_ACC;
        S_ACC:   if (w_last)  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q    <= 1'b0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else begin
      if (w_accept && w_first) r_mode_q <= bus.mode;
      if (w_accept && w_last) begin
        r_out_valid <= 1'b1;
        r_data_out  <= w_result;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // NOTE: accumulators carry no reset; the first beat of every window overwrites them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < CHANNELS; i++) r_acc[i] <= w_acc_nxt[i];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.data_out  = r_data_out;
  assign bus.busy      = (r_state == S_ACC);

endmodule

// File: tb/tb_pooling_array_param.sv
// Directed bench for pooling_array_param (3 lanes x 16 bits, window 4) with hand-computed results.
// Every delivered result is captured at the clock edge it is consumed and compared in order.
module tb_pooling_array_param;

  localparam int DW = 16;
  localparam int CH = 3;
  localparam int BW = DW * CH;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] got_q [$];

  pooling_array_param_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

  pooling_array_param #(.DATA_WIDTH(DW), .CHANNELS(CH), .WINDOW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) got_q.push_back(bus.data_out);
  end

  function automatic logic [BW-1:0] pk(input int a, input int b, input int c);
    return {16'(a), 16'(b), 16'(c)};
  endfunction

  function automatic logic [BW-1:0] res(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 'x;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic clr, input logic m, input int a, input int b, input int c);
    bus.in_valid = v;
    bus.clear    = clr;
    bus.mode     = m;
    bus.data_in  = pk(a, b, c);
  endtask

  task automatic beat(input logic m, input int a, input int b, input int c);
    drive(1'b1, 1'b0, m, a, b, c);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick();
    tick();
    check("rst_out_valid", BW'(bus.out_valid), BW'(0));
    check("rst_data_out",  bus.data_out,       BW'(0));
    check("rst_busy",      BW'(bus.busy),      BW'(0));
    check("rst_in_ready",  BW'(bus.in_ready),  BW'(1));
    rst = 1'b0;
    tick();

    // Max mode
    beat(1'b0,  5, -8, 0);
    check("max_busy_b1", BW'(bus.busy), BW'(1));
    beat(1'b0, -3, -2, 0);
    beat(1'b0,  9, -7, 0);
    check("max_no_early_valid", BW'(bus.out_valid), BW'(0));
    beat(1'b0,  2, -4, 0);
    check("max_valid",    BW'(bus.out_valid), BW'(1));
    check("max_data",     bus.data_out,       pk(9, -2, 0));
    check("max_busy_end", BW'(bus.busy),      BW'(0));
    tick();
    check("max_valid_drop", BW'(bus.out_valid), BW'(0));
    check("max_count", BW'(got_q.size()), BW'(1));
    check("max_res",   res(0), pk(9, -2, 0));
    got_q.delete();

    // Average mode with floor on negative sums
    beat(1'b1, 1, -1, 4);
    beat(1'b1, 2, -1, 4);
    beat(1'b1, 3, -1, 4);
    beat(1'b1, 5, -2, 4);
    check("avg_data", bus.data_out, pk(2, -2, 4));
    tick();
    check("avg_count", BW'(got_q.size()), BW'(1));
    got_q.delete();

    // Backpressure across two windows
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 10, 20, 30);
    repeat (4) tick();
    check("bp_valid",    BW'(bus.out_valid), BW'(1));
    check("bp_in_ready", BW'(bus.in_ready),  BW'(0));
    check("bp_data_a",   bus.data_out,       pk(10, 20, 30));
    drive(1'b1, 1'b0, 1'b0, 1, 2, 3);
    repeat (3) tick();
    check("bp_hold_data",  bus.data_out,      pk(10, 20, 30));
    check("bp_hold_ready", BW'(bus.in_ready), BW'(0));
    check("bp_hold_busy",  BW'(bus.busy),     BW'(0));
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("bp_valid_b", BW'(bus.out_valid), BW'(1));
    check("bp_data_b",  bus.data_out,       pk(1, 2, 3));
    bus.in_valid = 1'b0;
    tick();
    check("bp_count", BW'(got_q.size()), BW'(2));
    check("bp_res0",  res(0), pk(10, 20, 30));
    check("bp_res1",  res(1), pk(1, 2, 3));
    got_q.delete();

    // Clear discards a partial window and drops the beat presented with it
    beat(1'b0, 100, 100, 100);
    beat(1'b0, 100, 100, 100);
    drive(1'b1, 1'b1, 1'b0, 99, 99, 99);
    tick();
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    check("clr_busy", BW'(bus.busy), BW'(0));
    repeat (4) beat(1'b0, 7, 7, 7);
    check("clr_data", bus.data_out, pk(7, 7, 7));
    tick();
    beat(1'b0, 1, 1, 1);
    beat(1'b0, 1, 1, 1);
    beat(1'b0, 1, 1, 1);
    drive(1'b1, 1'b1, 1'b0, 1, 1, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    check("clr_last_no_valid", BW'(bus.out_valid), BW'(0));
    check("clr_last_busy",     BW'(bus.busy),      BW'(0));
    tick();
    check("clr_count", BW'(got_q.size()), BW'(1));
    check("clr_res",   res(0), pk(7, 7, 7));
    got_q.delete();

    // Mode change mid-window takes effect only at the next window
    beat(1'b0, 5, -5,  1);
    beat(1'b1, 1,  1,  1);
    beat(1'b1, 2, -6,  0);
    beat(1'b1, 3, -1, -1);
    check("mode_hold_max", bus.data_out, pk(5, 1, 1));
    beat(1'b1, 8,  0, 0);
    beat(1'b0, 0, -3, 0);
    beat(1'b0, 0,  0, 2);
    beat(1'b0, 0,  0, 0);
    check("mode_next_avg", bus.data_out, pk(2, -1, 0));
    tick();
    check("mode_count", BW'(got_q.size()), BW'(2));
    got_q.delete();

    // Reset mid-window
    beat(1'b0, 50, 50, 50);
    beat(1'b0, 60, 60, 60);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 70, 70, 70);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    check("rstm_out_valid", BW'(bus.out_valid), BW'(0));
    check("rstm_data_out",  bus.data_out,       BW'(0));
    check("rstm_busy",      BW'(bus.busy),      BW'(0));
    check("rstm_in_ready",  BW'(bus.in_ready),  BW'(1));
    beat(1'b0,  1,  2,  3);
    beat(1'b0,  4,  5,  6);
    beat(1'b0, -7, -8, -9);
    check("rstm_no_early", BW'(bus.out_valid), BW'(0));
    beat(1'b0,  0,  0,  0);
    check("rstm_data", bus.data_out, pk(4, 5, 6));
    tick();
    tick();
    check("rstm_count", BW'(got_q.size()), BW'(1));
    check("rstm_res",   res(0), pk(4, 5, 6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
